// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: hazard unit for the 5-stage MIPS pipeline.
// It keeps a shadow E/M/W copy of the register tags and derives:
//   - EX-stage forwarding selects for ALU operand A, operand B and store data.
//   - A load-use interlock with a LOAD_STALL-cycle bubble train.
//   - Branch flush of IF/ID and ID/EX.
// Register 0 is never forwarded and never interlocked.
// Optional macro HAZ_PERF_EN adds saturating StallCnt/FlushCnt counters.
//
// Handshake note: there is no valid/ready traffic here. Every output is
// a per-cycle combinational level. Stall holds PC and IF/ID, FlushD clears
// IF/ID and BubbleE inserts a NOP into ID/EX, all at the next rising edge.
// fsm_state exposes the interlock state: 0 = IDLE, 1 = HOLD.
module hazard_fwd_ctrl #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [REG_AW-1:0] D_Rs,
    input  logic [REG_AW-1:0] D_Rt,
    input  logic              D_UseRt,
    input  logic [REG_AW-1:0] D_Rw,
    input  logic              D_RegWr,
    input  logic              D_MemRd,
    input  logic              D_MemWr,
    input  logic              D_ALUSrc,
    input  logic              E_BrTaken,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        FwdSt,
    output logic              Stall,
    output logic              FlushD,
    output logic              BubbleE,
`ifdef HAZ_PERF_EN
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushCnt,
`endif
    output logic              fsm_state
);

    typedef struct packed {
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rw;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
        logic              alu_src;
    } stage_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // The first bubble is issued from IDLE.
    // The counter then holds the number of HOLD bubbles still owed.
    localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL - 1);

    stage_t     e_q, m_q, w_q;
    stage_t     d_stage;
    state_t     state_q, state_nxt;
    logic [2:0] cnt_q, cnt_nxt;

    logic       hz;
    logic       stall_c, flush_c, bubble_c;
    logic [1:0] src_a_c, src_b_c, fwd_st_c;

    // A producer in a later stage matches when it writes a non-zero register equal to x.
    function automatic logic hit(input stage_t s, input logic [REG_AW-1:0] x);
        return s.reg_wr && (s.rw != '0) && (s.rw == x);
    endfunction

    assign d_stage = '{rs: D_Rs, rt: D_Rt, rw: D_Rw, reg_wr: D_RegWr,
                       mem_rd: D_MemRd, mem_wr: D_MemWr, alu_src: D_ALUSrc};

    // Shadow tag pipeline: advances every edge, even during Stall; only E is bubbled.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= bubble_c ? '0 : d_stage;
            m_q <= e_q;
            w_q <= m_q;
        end
    end

    // Forwarding selects for the instruction in EX. M wins over W because it is the younger producer.
    always_comb begin
        src_a_c  = 2'b00;
        src_b_c  = 2'b00;
        fwd_st_c = 2'b00;
        if (hit(m_q, e_q.rs))      src_a_c = 2'b01;
        else if (hit(w_q, e_q.rs)) src_a_c = 2'b10;
        if (e_q.alu_src)           src_b_c = 2'b11;
        else if (hit(m_q, e_q.rt)) src_b_c = 2'b01;
        else if (hit(w_q, e_q.rt)) src_b_c = 2'b10;
        if (e_q.mem_wr) begin
            if (hit(m_q, e_q.rt))      fwd_st_c = 2'b01;
            else if (hit(w_q, e_q.rt)) fwd_st_c = 2'b10;
        end
    end

    // Load-use hazard: a load in EX feeds a source of the instruction in ID.
    // A dependent store also stalls because there is no M-to-M path.
    assign hz = e_q.mem_rd && (e_q.rw != '0) &&
                ((e_q.rw == D_Rs) || (D_UseRt && (e_q.rw == D_Rt)));

    // Interlock state and bubble counter registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Next-state logic: a taken branch overrides everything.
    // HOLD ignores hz because the load has already left EX.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        stall_c   = 1'b0;
        flush_c   = 1'b0;
        bubble_c  = 1'b0;
        if (E_BrTaken) begin
            flush_c   = 1'b1;
            bubble_c  = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hz) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_nxt = HOLD;
                            cnt_nxt   = CNT_INIT;
                        end
                    end
                end
                HOLD: begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    cnt_nxt  = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 3'd0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    // Every output reads 0 while reset is asserted, including the FlushD path that comes straight from E_BrTaken.
    always_comb begin
        ALUSrcA = Reset_n ? src_a_c  : 2'b00;
        ALUSrcB = Reset_n ? src_b_c  : 2'b00;
        FwdSt   = Reset_n ? fwd_st_c : 2'b00;
        Stall   = Reset_n & stall_c;
        FlushD  = Reset_n & flush_c;
        BubbleE = Reset_n & bubble_c;
    end

    assign fsm_state = state_q;

`ifdef HAZ_PERF_EN
    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            StallCnt <= 32'd0;
            FlushCnt <= 32'd0;
        end else begin
            if (stall_c && (StallCnt != 32'hFFFF_FFFF)) StallCnt <= StallCnt + 32'd1;
            if (flush_c && (FlushCnt != 32'hFFFF_FFFF)) FlushCnt <= FlushCnt + 32'd1;
        end
    end
`endif

    // The shadow stages carry full records, but only some fields are consumed downstream.
    logic unused_fields;
    assign unused_fields = ^{e_q.reg_wr,
                             m_q.rs, m_q.rt, m_q.mem_rd, m_q.mem_wr, m_q.alu_src,
                             w_q.rs, w_q.rt, w_q.mem_rd, w_q.mem_wr, w_q.alu_src};

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Next-generation hazard unit for the 5-stage MIPS pipeline.
- Keeps its own shadow copy of the E/M/W register-tag pipeline, so upstream only supplies decode-stage fields.
- Produces EX-stage forwarding selects for ALU operand A, ALU operand B and store data.
- Adds a load-use interlock FSM with a parametrised stall length, branch flush, and r0 exclusion.

Parameters:
REG_AW, 5, register address width; register 0 is hard-wired zero and is never forwarded or interlocked.
LOAD_STALL, 1, bubbles inserted on a load-use hazard (1..7; covers multi-cycle data memory).

Ports:
Clk  input  1  pipeline clock, rising edge.
Reset_n  input  1  asynchronous active-low reset.
D_Rs  input  REG_AW  ID-stage first source register.
D_Rt  input  REG_AW  ID-stage second source register.
D_UseRt  input  1  ID instruction reads Rt (R-type ALU, store, branch).
D_Rw  input  REG_AW  ID-stage destination register.
D_RegWr  input  1  ID instruction writes the register file.
D_MemRd  input  1  ID instruction is a load.
D_MemWr  input  1  ID instruction is a store.
D_ALUSrc  input  1  ID instruction uses an immediate as ALU operand B.
E_BrTaken  input  1  branch/jump resolved taken in EX this cycle.
ALUSrcA  output  2  EX operand A select: 00 regfile, 01 M result, 10 W result.
ALUSrcB  output  2  EX operand B select: 00/01/10 as above, 11 immediate.
FwdSt  output  2  EX store-data select: 00 regfile, 01 M, 10 W.
Stall  output  1  hold PC and IF/ID this cycle.
FlushD  output  1  clear IF/ID at the next edge.
BubbleE  output  1  ID/EX loads a NOP at the next edge.

Behaviour:
- Shadow registers E_, M_, W_ each hold {Rs, Rt, Rw, RegWr, MemRd, MemWr, ALUSrc}.
- Every edge: W<=M, M<=E.
- E<=D unless BubbleE=1, in which case E<=bubble (all control bits 0, tags 0).
- Reset (asynchronous, also mid-stall): all shadow registers 0, FSM IDLE, counter 0. ALUSrcA/B, FwdSt, Stall, FlushD and BubbleE read 0 while Reset_n=0.
- Forwarding is combinational from the E, M and W shadow registers. Zero latency; selects are valid in the same cycle the instruction sits in EX.
  - hitM(x) = M_RegWr && M_Rw!=0 && M_Rw==x; hitW(x) is the same using W fields.
  - ALUSrcA = hitM(E_Rs)?01 : hitW(E_Rs)?10 : 00. M has priority over W.
  - ALUSrcB = E_ALUSrc?11 : hitM(E_Rt)?01 : hitW(E_Rt)?10 : 00.
  - FwdSt = E_MemWr ? (hitM(E_Rt)?01 : hitW(E_Rt)?10 : 00) : 00. Independent of E_ALUSrc.
- Load-use detect:
  - hz = E_MemRd && E_Rw!=0 && (E_Rw==D_Rs || (D_UseRt && E_Rw==D_Rt)).
  - A load followed by a store that uses the loaded value only as store data still stalls; no M-to-M path exists.
- FSM:
  - IDLE: if hz and !E_BrTaken -> Stall=1, BubbleE=1, cnt<=LOAD_STALL-1. Go to HOLD if LOAD_STALL>1, else stay IDLE.
  - HOLD: Stall=1, BubbleE=1, cnt decrements each cycle. When cnt==0 this cycle is the last bubble; return to IDLE.
  - While in HOLD, hz is not re-evaluated. The load has already left E.
- Branch flush: E_BrTaken=1 -> FlushD=1, BubbleE=1, Stall=0.
  - Flush overrides a simultaneous hz.
  - In HOLD, flush forces FSM to IDLE and clears cnt.
- Forward priority when the same Rw appears in M and W: M wins (youngest producer).
- Shadow pipeline advances during Stall; only the E input is bubbled.

Optional Feature:
- Macro HAZ_PERF_EN.
- Defined: adds outputs StallCnt[31:0] and FlushCnt[31:0].
  - They increment on each cycle with Stall=1 or FlushD=1 respectively.
  - They saturate at 32'hFFFFFFFF and reset to 0 on Reset_n.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- add r3,r1,r2 then sub r4,r3,r5 -> in sub's EX cycle ALUSrcA=01, ALUSrcB=00. With one independent instruction between them: ALUSrcA=10.
- addi r0,r1,5 then add r6,r0,r0 -> ALUSrcA=00, ALUSrcB=00 (r0 never forwarded).
- lw r2,0(r1) then add r4,r2,r2, LOAD_STALL=1 -> exactly one cycle Stall=1/BubbleE=1, then ALUSrcA=10. With LOAD_STALL=3: three consecutive stall cycles.
- add r7,.. then sw r7,4(r8) -> store in EX: ALUSrcB=11, FwdSt=01.
- lw r2 then dependent add while E_BrTaken=1 in the same cycle -> FlushD=1, BubbleE=1, Stall=0. Assert Reset_n=0 during a LOAD_STALL=3 HOLD -> all outputs 0 immediately; after release, FSM is IDLE.
- HAZ_PERF_EN defined: the LOAD_STALL=3 hazard followed by one taken branch -> StallCnt=3, FlushCnt=1.
